snake_input_ctrl: RTL
=====================

Name: snake_input_ctrl

Overview:
Sits between periphery_control and the snake game logic. It synchronises and debounces the eight button levels and turns them into one-cycle press events. Direction presses are queued in a small FIFO and released one per game tick. The block also owns the pause/run state toggled by Start.

Parameters:
DEBOUNCE_CYCLES, 500000, sample-strobe period in clk cycles (10 ms at 50 MHz); bench uses 4
FIFO_DEPTH, 4, direction queue depth, power of 2, minimum 2

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
A, B, Select, Start, Up, Down, Left, Right  in  1 each  raw button levels from periphery_control, asynchronous
tick  in  1  one-cycle game-step strobe
dir_out  out  2  current snake direction: 0 Up, 1 Down, 2 Left, 3 Right
dir_changed  out  1  one-cycle pulse when dir_out is loaded from the FIFO
a_press, b_press, select_press, start_press  out  1 each  one-cycle press pulses
paused  out  1  game paused flag
fifo_count  out  $clog2(FIFO_DEPTH)+1  queued directions
overflow  out  1  sticky: a direction was dropped because the FIFO was full; cleared by reset only

Behaviour:
- Reset (asynchronous, resetN=0):
  - dir_out=3 (Right); paused=0; fifo_count=0; overflow=0.
  - All pulse outputs=0; synchronisers, debounce state and prescaler cleared.
- Synchronisation: each raw input passes through a 2-flop synchroniser.
- Debounce:
  - Shared prescaler counts 0..DEBOUNCE_CYCLES-1; the sample strobe fires when count==DEBOUNCE_CYCLES-1, then the counter wraps to 0.
  - On each strobe, each button shifts its synchronised level into a 3-bit history.
  - The debounced level becomes 1 when the history is 111 and 0 when it is 000; otherwise it holds.
- Press pulse: asserted for exactly one cycle, the cycle after the debounced level rises 0->1. Releases generate nothing.
- Direction arbitration:
  - If several direction presses occur in the same cycle, only one is taken, priority Up>Down>Left>Right.
  - Reference direction = last FIFO entry if fifo_count>0, else dir_out.
  - The candidate is rejected if it equals the reference or is its opposite (Up/Down, Left/Right).
  - If the candidate is accepted and the FIFO is full, it is dropped and overflow is set.
- Pop:
  - On tick with paused=0 and fifo_count>0: dir_out<=head, dir_changed=1 on the next cycle, head is removed.
  - On tick with an empty FIFO or paused=1: no change and no pulse.
- Simultaneous push and pop in the same cycle:
  - Both happen and fifo_count is unchanged.
  - The reference for the push is taken from pre-pop state.
  - A push into a full FIFO that is popping in the same cycle is accepted, not dropped.
- Pause:
  - start_press toggles paused.
  - Entering pause flushes the FIFO (fifo_count=0).
  - Direction presses while paused=1 are discarded.
  - dir_out holds across pause.
- Release: select_press, a_press and b_press are pure pass-through events; the game consumes them.
- Reset mid-operation (resetN low at any time): everything returns to reset values immediately; in-flight debounce histories are lost.

Optional Feature:
ALLOW_REVERSE_EN
- Defined: the opposite-direction rejection is removed; only candidates equal to the reference are rejected. Used for the "reverse snake" game mode.
- Undefined: opposite directions are rejected as above.

Test Plan:
1. DEBOUNCE_CYCLES=4, reset, Up held high for 40 cycles -> exactly one a single-cycle direction accept. fifo_count=1 within 2+3*4+2=16 cycles of the edge. No second event while the button is held.
2. Up toggling every 3 cycles (glitch faster than a strobe period) for 60 cycles -> no press and fifo_count stays 0. Then Up held -> one accept.
3. From reset (dir_out=3), press Left -> rejected (opposite). Press Up, Right, Down -> fifo_count=3. Three ticks -> dir_out 0, 3, 1 in order, each with a one-cycle dir_changed pulse.
4. Five distinct accepted presses (Up, Left, Down, Right, Up) with no tick -> fifo_count=4, overflow=1. Then a tick coincident with an accepted press -> fifo_count stays 4 and overflow does not re-trigger that cycle.
5. Queue 2 entries, press Start -> start_press pulse, paused=1, fifo_count=0. Ticks produce no dir_changed. Press Start again -> paused=0.
6. Assert resetN=0 mid-debounce with fifo_count=2 and dir_out=0 -> outputs go to dir_out=3, fifo_count=0, overflow=0, paused=0 without a clock edge. Repeat scenario 3's Left press with ALLOW_REVERSE_EN defined -> accepted and fifo_count=1.

Source files
------------

// File: rtl/snake_input_ctrl.sv
// snake_input_ctrl: button front end for the snake game.
// Synchronises and debounces the eight raw button levels and turns them into
// one-cycle press events. Direction presses are arbitrated, filtered against
// the current heading and queued, then released one per game tick. It also
// owns the pause/run state toggled by Start.
//
// Optional build macro: ALLOW_REVERSE_EN. When defined, the opposite-direction
// rejection is removed ("reverse snake" mode).
//
// Ports:
//   clk, resetN                     clock, asynchronous active-low reset
//   A, B, Select, Start             raw button levels (asynchronous)
//   Up, Down, Left, Right           raw direction button levels (asynchronous)
//   tick                            one-cycle game-step strobe
//   dir_out                         current direction: 0 Up, 1 Down, 2 Left, 3 Right
//   dir_changed                     one-cycle pulse when dir_out is loaded from the queue
//   a_press/b_press/select_press/start_press  one-cycle press pulses
//   paused                          game paused flag
//   fifo_count                      number of queued directions
//   overflow                        sticky: an accepted direction was dropped (queue full)
module snake_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic                          A,
  input  logic                          B,
  input  logic                          Select,
  input  logic                          Start,
  input  logic                          Up,
  input  logic                          Down,
  input  logic                          Left,
  input  logic                          Right,
  input  logic                          tick,
  output logic [1:0]                    dir_out,
  output logic                          dir_changed,
  output logic                          a_press,
  output logic                          b_press,
  output logic                          select_press,
  output logic                          start_press,
  output logic                          paused,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int unsigned NBTN  = 8;
  localparam int unsigned PRE_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Button bit order: 0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right
  logic [NBTN-1:0]      raw, sync1, sync2, deb, deb_nxt, rise_c, press;
  logic [NBTN-1:0][1:0] hist;
  logic [PRE_W-1:0]     pre_cnt;
  logic                 strobe_c;

  logic [1:0]           mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_ptr, wr_ptr, last_idx;
  logic [1:0]           cand_c, ref_c;
  logic                 cand_vld_c, accept_c, pop_c, push_c, full_c, flush_c;

  assign raw      = {Right, Left, Down, Up, Start, Select, B, A};
  assign strobe_c = (pre_cnt == PRE_W'(DEBOUNCE_CYCLES - 1));

  // Debounce decision. Only the two older samples are stored; the newest
  // sample is the synchronised level at the strobe, so the 3-bit history is
  // {hist, sync2}. Between strobes the history cannot change, so deb holds.
  always_comb begin
    deb_nxt = deb;
    for (int i = 0; i < NBTN; i++) begin
      if (strobe_c) begin
        if ({hist[i], sync2[i]} == 3'b111)      deb_nxt[i] = 1'b1;
        else if ({hist[i], sync2[i]} == 3'b000) deb_nxt[i] = 1'b0;
      end
    end
    rise_c = deb_nxt & ~deb;
  end

  // Synchronisers, shared prescaler, histories and press pulses
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sync1   <= '0;
      sync2   <= '0;
      pre_cnt <= '0;
      hist    <= '0;
      deb     <= '0;
      press   <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      pre_cnt <= strobe_c ? '0 : pre_cnt + PRE_W'(1);
      if (strobe_c) begin
        for (int i = 0; i < NBTN; i++) hist[i] <= {hist[i][0], sync2[i]};
      end
      deb     <= deb_nxt;
      press   <= rise_c;
    end
  end

  assign a_press      = press[0];
  assign b_press      = press[1];
  assign select_press = press[2];
  assign start_press  = press[3];

  // Direction arbitration, filtering and queue control
  always_comb begin
    last_idx   = wr_ptr - PTR_W'(1);
    cand_vld_c = (|press[7:4]) & ~paused;
    cand_c     = 2'd3;
    if (press[4])      cand_c = 2'd0;
    else if (press[5]) cand_c = 2'd1;
    else if (press[6]) cand_c = 2'd2;
    // Reference is taken from pre-pop state
    ref_c      = (fifo_count != '0) ? mem[last_idx] : dir_out;
`ifdef ALLOW_REVERSE_EN
    accept_c   = cand_vld_c && (cand_c != ref_c);
`else
    accept_c   = cand_vld_c && (cand_c != ref_c) && (cand_c != {ref_c[1], ~ref_c[0]});
`endif
    pop_c      = tick & ~paused & (fifo_count != '0);
    full_c     = (fifo_count == CNT_W'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full queue still accepts
    push_c     = accept_c & (~full_c | pop_c);
    flush_c    = press[3] & ~paused;
  end

  // Queue storage; contents need no reset since fifo_count gates every read
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= cand_c;
  end

  // Queue pointers, direction, pause and overflow state
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_count  <= '0;
      dir_out     <= 2'd3;
      dir_changed <= 1'b0;
      paused      <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      dir_changed <= pop_c;
      if (pop_c) begin
        dir_out <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + PTR_W'(1);
      end
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (accept_c && full_c && !pop_c) overflow <= 1'b1;
      fifo_count <= fifo_count + CNT_W'(push_c) - CNT_W'(pop_c);
      if (press[3]) paused <= ~paused;
      // Entering pause discards everything queued, including this cycle's push
      if (flush_c) begin
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        fifo_count <= '0;
      end
    end
  end

endmodule
